// File: rtl/mux_sel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : mux_sel_serializer
// Brief    : Captures a parallel word, drives it onto an external 8:1 mux tree
//            and walks the select to emit the word one bit per transfer.
//            Optional trailing even-parity bit under `MUX_SER_PARITY_EN.
// Revision : 1.0
// ============================================================================
module mux_sel_serializer #(
    parameter int SEL_W     = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [2**SEL_W-1:0]   load_data,
    output logic [2**SEL_W-1:0]   mux_i,
    output logic [SEL_W-1:0]      mux_s,
    input  logic                  mux_y,
    output logic                  ser_valid,
    input  logic                  ser_ready,
    output logic                  ser_data,
    output logic                  ser_last,
    output logic                  busy
);

    localparam int N = 2**SEL_W;

    localparam logic [SEL_W-1:0] c_first = (MSB_FIRST != 0) ? '1 : '0;
    localparam logic [SEL_W-1:0] c_final = (MSB_FIRST != 0) ? '0 : '1;
    localparam logic [SEL_W-1:0] c_one   = {{(SEL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef MUX_SER_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_SHIFT  = 2'd1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_mux_i;
    logic [SEL_W-1:0]   r_mux_s;
    logic               w_load;
    logic               w_step;
    logic               w_final;
`ifdef MUX_SER_PARITY_EN
    logic               r_par;
`endif

    assign mux_i   = r_mux_i;
    assign mux_s   = r_mux_s;
    assign w_final = (r_mux_s == c_final);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mux_i <= '0;
            r_mux_s <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mux_i <= load_data;
                r_mux_s <= c_first;
            end else if (w_step) begin
                r_mux_s <= (MSB_FIRST != 0) ? (r_mux_s - c_one) : (r_mux_s + c_one);
            end
        end
    end

`ifdef MUX_SER_PARITY_EN
    // Running XOR of every bit actually handed to the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_load) begin
            r_par <= 1'b0;
        end else if ((r_state == S_SHIFT) && ser_ready) begin
            r_par <= r_par ^ mux_y;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_data    = 1'b0;
        ser_last    = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = !rst;
                if (load_valid && !rst) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_data  = mux_y;
`ifdef MUX_SER_PARITY_EN
                ser_last  = 1'b0;
`else
                ser_last  = w_final;
`endif
                if (ser_ready) begin
                    if (w_final) begin
`ifdef MUX_SER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
`ifdef MUX_SER_PARITY_EN
            S_PARITY: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_data  = r_par;
                ser_last  = 1'b1;
                if (ser_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_sel_serializer
// Brief    : Self-checking bench; instance 0 is LSB-first, instance 1 MSB-first.
// Revision : 1.0
// ============================================================================
module tb_mux_sel_serializer;

    localparam int N = 8;
`ifdef MUX_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk;
    logic       rst;
    logic       load_valid [2];
    logic       load_ready [2];
    logic [7:0] load_data  [2];
    logic [7:0] mux_i      [2];
    logic [2:0] mux_s      [2];
    logic       mux_y      [2];
    logic       ser_valid  [2];
    logic       ser_ready  [2];
    logic       ser_data   [2];
    logic       ser_last   [2];
    logic       busy       [2];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mux_sel_serializer #(.SEL_W(3), .MSB_FIRST(g)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .load_valid (load_valid[g]),
            .load_ready (load_ready[g]),
            .load_data  (load_data[g]),
            .mux_i      (mux_i[g]),
            .mux_s      (mux_s[g]),
            .mux_y      (mux_y[g]),
            .ser_valid  (ser_valid[g]),
            .ser_ready  (ser_ready[g]),
            .ser_data   (ser_data[g]),
            .ser_last   (ser_last[g]),
            .busy       (busy[g])
        );
        // The 8:1 mux tree that lives beside the block at the parent level
        assign mux_y[g] = mux_i[g][mux_s[g]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bit k of the frame is word[k] (LSB-first) or word[N-1-k]
    // (MSB-first); an optional final bit carries the XOR of the word.
    task automatic frame(input int d, input logic [7:0] word, input int mode,
                         input int abort_at, input bit hold, input logic [7:0] nxt);
        int L;
        int k;
        int cyc;
        int idx;
        logic [7:0] rx;
        logic rdy;
        L   = N + PAR;
        k   = 0;
        cyc = 0;
        rx  = '0;
        check("idle_load_ready", load_ready[d], 1);
        load_valid[d] = 1'b1;
        load_data[d]  = word;
        ser_ready[d]  = 1'b0;
        @(negedge clk);
        if (hold) load_data[d] = nxt;
        else      load_valid[d] = 1'b0;
        while (k < L && cyc < 200) begin
            if (abort_at > 0 && k == abort_at) begin
                rst = 1'b1;
                ser_ready[d] = 1'b0;
                @(negedge clk);
                check("abort_load_ready", load_ready[d], 0);
                rst = 1'b0;
                @(negedge clk);
                check("abort_valid", ser_valid[d], 0);
                check("abort_mux_s", mux_s[d], 0);
                check("abort_mux_i", mux_i[d], 0);
                check("abort_busy", busy[d], 0);
                check("abort_last", ser_last[d], 0);
                check("abort_load_ready_after", load_ready[d], 1);
                return;
            end
            if (k < N) idx = (d == 1) ? (N - 1 - k) : k;
            else       idx = (d == 1) ? 0 : (N - 1);
            check("valid", ser_valid[d], 1);
            check("busy", busy[d], 1);
            check("load_ready_in_frame", load_ready[d], 0);
            check("mux_s", mux_s[d], idx);
            check("mux_i", mux_i[d], word);
            check("data", ser_data[d], (k < N) ? word[idx] : ^word);
            check("last", ser_last[d], (k == L - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ser_ready[d] = rdy;
            if (rdy) begin
                if (k < N) rx[idx] = ser_data[d];
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        ser_ready[d] = 1'b0;
        check("frame_len", k, L);
        check("rx_word", rx, word);
        check("end_valid", ser_valid[d], 0);
        check("end_busy", busy[d], 0);
        check("end_last", ser_last[d], 0);
        check("end_load_ready", load_ready[d], 1);
    endtask

    initial begin
        logic [7:0] w;
        int d;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            load_valid[i] = 1'b0;
            load_data[i]  = '0;
            ser_ready[i]  = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check("rst_load_ready", load_ready[0], 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_valid", ser_valid[i], 0);
            check("reset_last", ser_last[i], 0);
            check("reset_busy", busy[i], 0);
            check("reset_mux_s", mux_s[i], 0);
            check("reset_mux_i", mux_i[i], 0);
            check("reset_load_ready", load_ready[i], 1);
        end

        frame(0, 8'hA5, 0, 0, 1'b0, 8'h00);
        frame(1, 8'h81, 0, 0, 1'b0, 8'h00);
        frame(0, 8'h3C, 1, 0, 1'b0, 8'h00);
        frame(0, 8'hFF, 0, 3, 1'b0, 8'h00);
        frame(0, 8'h01, 0, 0, 1'b0, 8'h00);

        // Reset coincident with a load request must capture nothing
        rst = 1'b1;
        load_valid[0] = 1'b1;
        load_data[0]  = 8'h5A;
        @(negedge clk);
        check("rst_load_mux_i", mux_i[0], 0);
        check("rst_load_busy", busy[0], 0);
        check("rst_load_ready", load_ready[0], 0);
        rst = 1'b0;
        load_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_load_idle_valid", ser_valid[0], 0);

        frame(0, 8'h12, 0, 0, 1'b1, 8'h34);
        frame(0, 8'h34, 0, 0, 1'b0, 8'h00);

        frame(0, 8'h07, 0, 0, 1'b0, 8'h00);
        frame(0, 8'h03, 0, 0, 1'b0, 8'h00);
        frame(1, 8'h07, 2, 0, 1'b0, 8'h00);

        for (int n = 0; n < 24; n++) begin
            w = 8'($urandom);
            d = int'($urandom_range(0, 1));
            frame(d, w, 2, 0, 1'b0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
